// File: rtl/midi_voice_alloc_pkg.sv
// Shared MIDI constants for the voice allocator.
//   MSG_*      : status nibbles accepted from midi_in
//   CC_*       : controller numbers with special meaning
//   msg_ok()   : true for the status nibbles the allocator reacts to
package midi_voice_alloc_pkg;

    localparam logic [3:0] MSG_NOTE_OFF = 4'b1000;
    localparam logic [3:0] MSG_NOTE_ON  = 4'b1001;
    localparam logic [3:0] MSG_CC       = 4'b1011;

    localparam logic [6:0] CC_SUSTAIN   = 7'd64;
    localparam logic [6:0] CC_ALL_OFF   = 7'd123;

    function automatic logic msg_ok(input logic [3:0] msg);
        return (msg == MSG_NOTE_OFF) || (msg == MSG_NOTE_ON) || (msg == MSG_CC);
    endfunction

endpackage

// File: rtl/midi_voice_alloc_voice_pick.sv
// voice_pick: combinational target selection for a NOTE ON.
//   gate/notes/ranks : current per-voice state (rank 0 = newest)
//   in_note          : incoming note number
//   idx              : chosen voice
//   hit              : a gated voice already plays in_note (retrigger)
//   free             : no hit, and some voice is ungated (lowest index chosen)
//   stl              : no hit and no free voice; oldest voice chosen
module voice_pick #(
    parameter int VOICES = 4,
    parameter int RW     = 2
) (
    input  logic [VOICES-1:0]         gate,
    input  logic [VOICES-1:0][6:0]    notes,
    input  logic [VOICES-1:0][RW-1:0] ranks,
    input  logic [6:0]                in_note,
    output logic [RW-1:0]             idx,
    output logic                      hit,
    output logic                      free,
    output logic                      stl
);

    logic [RW-1:0] hit_idx, free_idx, old_idx;
    logic          any_hit, any_free;

    // Scan downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        any_hit  = 1'b0;
        any_free = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        old_idx  = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (gate[i] && notes[i] == in_note) begin
                any_hit = 1'b1;
                hit_idx = RW'(i);
            end
            if (!gate[i]) begin
                any_free = 1'b1;
                free_idx = RW'(i);
            end
            if (ranks[i] == RW'(VOICES - 1))
                old_idx = RW'(i);
        end
    end

    always_comb begin
        hit  = any_hit;
        free = !any_hit && any_free;
        stl  = !any_hit && !any_free;
        idx  = any_hit ? hit_idx : (any_free ? free_idx : old_idx);
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: polyphonic voice allocator between midi_in and the
// per-voice note2dds/dds/ADSR chains.
//   clk, rst_n          : clock, synchronous active-low reset
//   ch_message/chan     : status nibble and channel, valid one cycle per message
//   note, lsb, msb      : note number, data byte 1, data byte 2
//   voice_gate          : per-voice gate (held or sustained)
//   voice_trig          : one-cycle pulse when a voice is (re)triggered
//   voice_note/vel      : per-voice note and velocity, 7 bits per voice
//   steal               : one-cycle pulse when an active voice was taken over
module midi_voice_alloc
    import midi_voice_alloc_pkg::*;
#(
    parameter int VOICES    = 4,
    parameter int OMNI      = 1,
    parameter int MIDI_CHAN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            ch_message,
    input  logic [3:0]            chan,
    input  logic [6:0]            note,
    input  logic [6:0]            lsb,
    input  logic [6:0]            msb,
    output logic [VOICES-1:0]     voice_gate,
    output logic [VOICES-1:0]     voice_trig,
    output logic [7*VOICES-1:0]   voice_note,
    output logic [7*VOICES-1:0]   voice_vel,
    output logic                  steal
);

    localparam int RW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [VOICES-1:0][6:0]    note_v, vel_v;
    logic [VOICES-1:0][RW-1:0] rank_v;
    logic [VOICES-1:0]         gate_v, trig_v;
    logic                      sustain;

    logic          chan_ok, acc, is_on, is_off, is_cc, sus_set, sus_fall, all_off;
    logic [RW-1:0] tgt, tgt_rank;
    logic          pk_hit, pk_free, pk_stl;

    always_comb begin
        chan_ok  = (OMNI != 0) || (chan == 4'(MIDI_CHAN));
        acc      = chan_ok && msg_ok(ch_message);
        // NOTE ON with velocity 0 is the running-status form of NOTE OFF.
        is_on    = acc && ch_message == MSG_NOTE_ON && msb != 7'd0;
        is_off   = acc && (ch_message == MSG_NOTE_OFF ||
                           (ch_message == MSG_NOTE_ON && msb == 7'd0));
        is_cc    = acc && ch_message == MSG_CC;
        sus_set  = is_cc && lsb == CC_SUSTAIN;
        sus_fall = sus_set && sustain && !msb[6];
        all_off  = is_cc && lsb == CC_ALL_OFF;
        tgt_rank = rank_v[tgt];
    end

    voice_pick #(.VOICES(VOICES), .RW(RW)) u_pick (
        .gate    (gate_v),
        .notes   (note_v),
        .ranks   (rank_v),
        .in_note (note),
        .idx     (tgt),
        .hit     (pk_hit),
        .free    (pk_free),
        .stl     (pk_stl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sustain <= 1'b0;
            steal   <= 1'b0;
        end else begin
            steal <= is_on && pk_stl;
            if (sus_set)
                sustain <= msb[6];
        end
    end

    for (genvar i = 0; i < VOICES; i++) begin : g_voice
        logic          g, h, t;
        logic [6:0]    n, v;
        logic [RW-1:0] r;
        logic          sel, off_hit;

        always_comb begin
            sel     = is_on && tgt == RW'(i);
            off_hit = is_off && g && n == note;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                g <= 1'b0;
                h <= 1'b0;
                t <= 1'b0;
                n <= '0;
                v <= '0;
                r <= RW'(i);
            end else begin
                t <= 1'b0;
                if (sel) begin
                    // A retrigger keeps its note; fresh or stolen voices load it.
                    if (pk_free || pk_stl) begin
                        n <= note;
                        g <= 1'b1;
                    end
                    v <= msb;
                    t <= 1'b1;
                    h <= 1'b0;
                    r <= '0;
                end else if (is_on && r < tgt_rank) begin
                    // Only voices newer than the target age; ranks stay a permutation.
                    r <= r + RW'(1);
                end
                if (off_hit) begin
                    if (sustain) h <= 1'b1;
                    else         g <= 1'b0;
                end
                if ((sus_fall && h) || all_off) begin
                    g <= 1'b0;
                    h <= 1'b0;
                end
            end
        end

        assign note_v[i] = n;
        assign vel_v[i]  = v;
        assign rank_v[i] = r;
        assign gate_v[i] = g;
        assign trig_v[i] = t;
    end

    assign voice_gate = gate_v;
    assign voice_trig = trig_v;
    assign voice_note = note_v;
    assign voice_vel  = vel_v;

endmodule

// File: tb/tb_midi_voice_alloc.sv
module tb_midi_voice_alloc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ch_message = 4'h0;
    logic [3:0]  chan = 4'h0;
    logic [6:0]  note = 7'd0, lsb = 7'd0, msb = 7'd0;

    logic [3:0]  a_gate, a_trig, b_gate, b_trig;
    logic [27:0] a_note, a_vel, b_note, b_vel;
    logic        a_steal, b_steal;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    midi_voice_alloc #(.VOICES(4), .OMNI(1), .MIDI_CHAN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ch_message(ch_message), .chan(chan),
        .note(note), .lsb(lsb), .msb(msb),
        .voice_gate(a_gate), .voice_trig(a_trig), .voice_note(a_note),
        .voice_vel(a_vel), .steal(a_steal)
    );

    midi_voice_alloc #(.VOICES(4), .OMNI(0), .MIDI_CHAN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ch_message(ch_message), .chan(chan),
        .note(note), .lsb(lsb), .msb(msb),
        .voice_gate(b_gate), .voice_trig(b_trig), .voice_note(b_note),
        .voice_vel(b_vel), .steal(b_steal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model for dut_a: voices as plain arrays, age as a queue of
    // voice indices with the newest voice at the front.
    bit mg[4], mh[4], mt[4];
    int mn[4], mv[4];
    bit ms, msus, chk_en = 1'b0;
    int q[$];

    task automatic model_step();
        int k, pos;
        for (int i = 0; i < 4; i++) mt[i] = 1'b0;
        ms = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mg[i] = 0; mh[i] = 0; mn[i] = 0; mv[i] = 0;
            end
            msus = 0;
            q = {0, 1, 2, 3};
            chk_en = 1'b1;
        end else if (ch_message == 4'h9 && msb != 0) begin
            k = -1;
            for (int i = 0; i < 4; i++) if (k < 0 && mg[i] && mn[i] == int'(note)) k = i;
            if (k >= 0) begin
                mv[k] = msb; mt[k] = 1; mh[k] = 0;
            end else begin
                for (int i = 0; i < 4; i++) if (k < 0 && !mg[i]) k = i;
                if (k < 0) begin
                    k = q[$];
                    ms = 1'b1;
                end
                mn[k] = note; mv[k] = msb; mg[k] = 1; mh[k] = 0; mt[k] = 1;
            end
            pos = 0;
            foreach (q[j]) if (q[j] == k) pos = j;
            q.delete(pos);
            q.push_front(k);
        end else if (ch_message == 4'h8 || ch_message == 4'h9) begin
            for (int i = 0; i < 4; i++)
                if (mg[i] && mn[i] == int'(note)) begin
                    if (msus) mh[i] = 1; else mg[i] = 0;
                end
        end else if (ch_message == 4'hB) begin
            if (lsb == 7'd64) begin
                if (msus && msb < 64)
                    for (int i = 0; i < 4; i++) if (mh[i]) begin mg[i] = 0; mh[i] = 0; end
                msus = (msb >= 64);
            end else if (lsb == 7'd123) begin
                for (int i = 0; i < 4; i++) begin mg[i] = 0; mh[i] = 0; end
            end
        end
    endtask

    always @(posedge clk) begin
        logic [3:0]  eg, et;
        logic [27:0] en, ev;
        model_step();
        #2;
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                eg[i] = mg[i];
                et[i] = mt[i];
                en[7*i +: 7] = 7'(mn[i]);
                ev[7*i +: 7] = 7'(mv[i]);
            end
            check("model_gate",  32'(a_gate),  32'(eg));
            check("model_trig",  32'(a_trig),  32'(et));
            check("model_note",  32'(a_note),  32'(en));
            check("model_vel",   32'(a_vel),   32'(ev));
            check("model_steal", 32'(a_steal), 32'(ms));
        end
    end

    task automatic send(input logic [3:0] m, input logic [3:0] c,
                        input logic [6:0] d1, input logic [6:0] d2);
        @(negedge clk);
        ch_message = m; chan = c; note = d1; lsb = d1; msb = d2;
        @(negedge clk);
        ch_message = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset state, first note
        do_reset();
        check("rst_gate", 32'(a_gate), 32'h0);
        check("rst_trig", 32'(a_trig), 32'h0);
        check("rst_steal", 32'(a_steal), 32'h0);
        send(4'h9, 4'h0, 7'd60, 7'd100);
        check("t1_gate", 32'(a_gate), 32'h1);
        check("t1_note0", 32'(a_note[6:0]), 32'd60);
        check("t1_vel0", 32'(a_vel[6:0]), 32'd100);
        check("t1_trig", 32'(a_trig), 32'h1);
        @(negedge clk);
        check("t1_trig_once", 32'(a_trig), 32'h0);

        // 2: fill and steal oldest
        do_reset();
        send(4'h9, 4'h0, 7'd60, 7'd90);
        send(4'h9, 4'h0, 7'd62, 7'd90);
        send(4'h9, 4'h0, 7'd64, 7'd90);
        send(4'h9, 4'h0, 7'd65, 7'd90);
        check("t2_full", 32'(a_gate), 32'hF);
        check("t2_nosteal", 32'(a_steal), 32'h0);
        send(4'h9, 4'h0, 7'd67, 7'd90);
        check("t2_steal", 32'(a_steal), 32'h1);
        check("t2_trig", 32'(a_trig), 32'h1);
        check("t2_note0", 32'(a_note[6:0]), 32'd67);
        send(4'h9, 4'h0, 7'd69, 7'd90);
        check("t2_steal_v1", 32'(a_trig), 32'h2);
        check("t2_note1", 32'(a_note[13:7]), 32'd69);

        // 3: sustain pedal
        do_reset();
        send(4'h9, 4'h0, 7'd60, 7'd80);
        send(4'hB, 4'h0, 7'd64, 7'd127);
        send(4'h8, 4'h0, 7'd60, 7'd0);
        check("t3_sustained", 32'(a_gate), 32'h1);
        send(4'hB, 4'h0, 7'd7, 7'd0);
        check("t3_other_cc", 32'(a_gate), 32'h1);
        send(4'hB, 4'h0, 7'd64, 7'd0);
        check("t3_released", 32'(a_gate), 32'h0);
        check("t3_note_kept", 32'(a_note[6:0]), 32'd60);

        // 4: retrigger, velocity-0 note off, ignored status
        do_reset();
        send(4'h9, 4'h0, 7'd60, 7'd100);
        send(4'h9, 4'h0, 7'd62, 7'd50);
        send(4'h9, 4'h0, 7'd60, 7'd20);
        check("t4_retrig", 32'(a_trig), 32'h1);
        check("t4_vel0", 32'(a_vel[6:0]), 32'd20);
        check("t4_vel1", 32'(a_vel[13:7]), 32'd50);
        check("t4_gate", 32'(a_gate), 32'h3);
        send(4'hA, 4'h0, 7'd62, 7'd0);
        check("t4_ignored", 32'(a_gate), 32'h3);
        send(4'h9, 4'h0, 7'd60, 7'd0);
        check("t4_vel0_off", 32'(a_gate), 32'h2);

        // 5: channel filter on dut_b, all notes off
        do_reset();
        send(4'h9, 4'h5, 7'd60, 7'd100);
        check("t5_b_filtered", 32'(b_gate), 32'h0);
        check("t5_a_omni", 32'(a_gate), 32'h1);
        send(4'h9, 4'h2, 7'd60, 7'd100);
        check("t5_b_accept", 32'(b_gate), 32'h1);
        check("t5_b_note0", 32'(b_note[6:0]), 32'd60);
        send(4'hB, 4'h2, 7'd123, 7'd0);
        check("t5_b_alloff", 32'(b_gate), 32'h0);
        check("t5_a_alloff", 32'(a_gate), 32'h0);

        // 6: reset mid-operation
        send(4'h9, 4'h0, 7'd40, 7'd10);
        send(4'h9, 4'h0, 7'd41, 7'd10);
        send(4'h9, 4'h0, 7'd42, 7'd10);
        send(4'h9, 4'h0, 7'd43, 7'd10);
        do_reset();
        check("t6_gate", 32'(a_gate), 32'h0);
        check("t6_trig", 32'(a_trig), 32'h0);
        send(4'h9, 4'h0, 7'd70, 7'd64);
        check("t6_first", 32'(a_gate), 32'h1);
        check("t6_note0", 32'(a_note[6:0]), 32'd70);
        send(4'h9, 4'h0, 7'd71, 7'd64);
        send(4'h9, 4'h0, 7'd72, 7'd64);
        send(4'h9, 4'h0, 7'd73, 7'd64);
        send(4'h9, 4'h0, 7'd74, 7'd64);
        check("t6_steal_v0", 32'(a_trig), 32'h1);
        check("t6_steal", 32'(a_steal), 32'h1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
